fft_sequencer: RTL

Control sequencer that drives the FFT address generator. On a start request it walks the transform through every stage and every butterfly pair (`o_stage`, `o_pair`, `o_en`), inserting a pipeline drain between stages so a stage never reads memory the previous stage has not finished writing. It also produces delayed copies of the issue stream, aligned to the write side of the butterfly pipeline, and reports completion to the top-level controller with a done pulse.

---
 rtl/fft_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fft_sequencer.sv
// FFT control sequencer: walks every stage and butterfly pair, drains the butterfly
// pipeline between stages, and emits a write-side copy of the issue stream.
module fft_sequencer #(
  parameter int LOG2N    = 10,
  parameter int PAIR_W   = 9,
  parameter int STAGE_W  = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_hold,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_en,
  output logic [STAGE_W-1:0] o_stage,
  output logic [PAIR_W-1:0]  o_pair,
  output logic               o_wr_en,
  output logic [STAGE_W-1:0] o_wr_stage,
  output logic [PAIR_W-1:0]  o_wr_pair,
  output logic               o_result_in_mem1
);

  localparam int                  DRAIN_W    = $clog2(PIPE_LAT + 1);
  localparam logic [PAIR_W-1:0]   PAIR_LAST  = {PAIR_W{1'b1}};
  localparam logic [STAGE_W-1:0]  STAGE_LAST = STAGE_W'(LOG2N - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [PAIR_W-1:0]    pair_q, pair_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 issue_s;

  logic                 en_line_q    [PIPE_LAT];
  logic [STAGE_W-1:0]   stage_line_q [PIPE_LAT];
  logic [PAIR_W-1:0]    pair_line_q  [PIPE_LAT];

  // Next-state and counter logic for the issue walk.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    drain_d = '0;
    issue_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        stage_d = '0;
        pair_d  = '0;
        if (i_start) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        issue_s = ~i_hold;
        if (issue_s) begin
          pair_d = pair_q + PAIR_W'(1);
          if (pair_q == PAIR_LAST) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          pair_d = '0;
          if (stage_q == STAGE_LAST) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            state_d = S_RUN;
          end
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        stage_d = '0;
        pair_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        stage_d = '0;
        pair_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      pair_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
      drain_q <= drain_d;
    end
  end

  // Write-side delay line; shifts every cycle so it stays aligned through holds and drains.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        en_line_q[i]    <= 1'b0;
        stage_line_q[i] <= '0;
        pair_line_q[i]  <= '0;
      end
    end else begin
      en_line_q[0]    <= issue_s;
      stage_line_q[0] <= stage_q;
      pair_line_q[0]  <= pair_q;
      for (int i = 1; i < PIPE_LAT; i++) begin
        en_line_q[i]    <= en_line_q[i-1];
        stage_line_q[i] <= stage_line_q[i-1];
        pair_line_q[i]  <= pair_line_q[i-1];
      end
    end
  end

  // Issue valid follows i_hold within the same cycle so a held pair is never issued.
  assign o_en             = issue_s;
  assign o_stage          = stage_q;
  assign o_pair           = pair_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = (state_q == S_DONE);
  assign o_wr_en          = en_line_q[PIPE_LAT-1];
  assign o_wr_stage       = stage_line_q[PIPE_LAT-1];
  assign o_wr_pair        = pair_line_q[PIPE_LAT-1];
  assign o_result_in_mem1 = (((LOG2N - 1) % 2) == 1);

endmodule
